// File: rtl/programmable_clock_divider_7_bit.sv
// Programmable 7-bit clock divider: free-running period counter, two magnitude
// comparators for wrap and high phase, and a req/ack load applied on period boundaries.

module magnitude_comparator_7_bit (
    input  logic [6:0] i_a,
    input  logic [6:0] i_b,
    output logic       o_lt,
    output logic       o_eq
);
    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);
endmodule

module programmable_clock_divider_7_bit #(
    parameter logic [6:0] DEFAULT_DIV  = 7'd4,
    parameter logic [6:0] DEFAULT_DUTY = 7'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load_req,
    input  logic [6:0] div_in,
    input  logic [6:0] duty_in,
    output logic       load_busy,
    output logic       load_ack,
    output logic       load_err,
    output logic [6:0] cnt_out,
    output logic       clk_out,
    output logic       tick
);
    logic [6:0] r_cnt;
    logic [6:0] r_div_act;
    logic [6:0] r_duty_act;
    logic [6:0] r_div_sh;
    logic [6:0] r_duty_sh;
    logic       r_pending;
    logic       r_load_ack;
    logic       r_load_err;
    logic       r_clk_out;
    logic       r_tick;

    logic [6:0] w_div_m1;
    logic       w_wrap;
    logic       w_high;
    logic       w_apply;
    logic       w_dummy_lt;
    logic       w_dummy_eq;

    assign w_div_m1 = r_div_act - 7'd1;

    magnitude_comparator_7_bit u_cmp_wrap (
        .i_a  (r_cnt),
        .i_b  (w_div_m1),
        .o_lt (w_dummy_lt),
        .o_eq (w_wrap)
    );

    magnitude_comparator_7_bit u_cmp_duty (
        .i_a  (r_cnt),
        .i_b  (r_duty_act),
        .o_lt (w_high),
        .o_eq (w_dummy_eq)
    );

    // A pending setting lands on the wrap edge while running, or immediately when idle,
    // so clk_out never shows a truncated period.
    assign w_apply = r_pending & (~en | w_wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 7'd0;
            r_div_act  <= DEFAULT_DIV;
            r_duty_act <= DEFAULT_DUTY;
            r_div_sh   <= 7'd0;
            r_duty_sh  <= 7'd0;
            r_pending  <= 1'b0;
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;

            if (en) begin
                r_cnt     <= w_wrap ? 7'd0 : r_cnt + 7'd1;
                r_clk_out <= w_high;
                r_tick    <= w_wrap;
            end else begin
                r_cnt     <= 7'd0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end

            // Requests arriving while a setting is pending (including the apply edge) are dropped.
            if (w_apply) begin
                r_div_act  <= r_div_sh;
                r_duty_act <= r_duty_sh;
                r_pending  <= 1'b0;
                r_load_ack <= 1'b1;
            end else if (load_req && !r_pending) begin
                if (div_in != 7'd0) begin
                    r_div_sh  <= div_in;
                    r_duty_sh <= duty_in;
                    r_pending <= 1'b1;
                end else begin
                    r_load_err <= 1'b1;
                end
            end
        end
    end

    assign load_busy = r_pending;
    assign load_ack  = r_load_ack;
    assign load_err  = r_load_err;
    assign cnt_out   = r_cnt;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;

    logic w_unused;
    assign w_unused = w_dummy_lt ^ w_dummy_eq;
endmodule

// File: tb/tb_programmable_clock_divider_7_bit.sv
// Directed bench for programmable_clock_divider_7_bit; expected values are hand-derived
// from the behavioural description (outputs lag cnt by one cycle).

module tb_programmable_clock_divider_7_bit;
    logic       clk;
    logic       rst;
    logic       en;
    logic       load_req;
    logic [6:0] div_in;
    logic [6:0] duty_in;
    logic       load_busy;
    logic       load_ack;
    logic       load_err;
    logic [6:0] cnt_out;
    logic       clk_out;
    logic       tick;

    int n_cmp;
    int n_fail;

    programmable_clock_divider_7_bit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load_req  (load_req),
        .div_in    (div_in),
        .duty_in   (duty_in),
        .load_busy (load_busy),
        .load_ack  (load_ack),
        .load_err  (load_err),
        .cnt_out   (cnt_out),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input bit co, input bit tk,
                       input bit busy, input bit ack, input bit err);
        logic [11:0] obs;
        logic [11:0] exp_v;
        obs   = {cnt_out, clk_out, tick, load_busy, load_ack, load_err};
        exp_v = {c[6:0], co, tk, busy, ack, err};
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed cnt=%0d clk_out=%b tick=%b busy=%b ack=%b err=%b, expected cnt=%0d clk_out=%b tick=%b busy=%b ack=%b err=%b",
                   tag, obs[11:5], obs[4], obs[3], obs[2], obs[1], obs[0],
                   exp_v[11:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input int c, input bit co, input bit tk,
                            input bit busy, input bit ack, input bit err);
        step();
        chk(tag, c, co, tk, busy, ack, err);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        load_req = 1'b0;
        div_in   = 7'd0;
        duty_in  = 7'd0;

        #12;
        chk("reset", 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        en  = 1'b1;

        // Defaults N=4, D=2
        step_chk("def_e1", 1, 1, 0, 0, 0, 0);
        step_chk("def_e2", 2, 1, 0, 0, 0, 0);
        step_chk("def_e3", 3, 0, 0, 0, 0, 0);
        step_chk("def_e4", 0, 0, 1, 0, 0, 0);
        step_chk("def_e5", 1, 1, 0, 0, 0, 0);

        // Load N=5, D=3 at cnt=1
        load_req = 1'b1; div_in = 7'd5; duty_in = 7'd3;
        step_chk("ld5_cap", 2, 1, 0, 1, 0, 0);
        load_req = 1'b0;
        step_chk("ld5_wait", 3, 0, 0, 1, 0, 0);
        step_chk("ld5_apply", 0, 0, 1, 0, 1, 0);
        step_chk("n5_c1", 1, 1, 0, 0, 0, 0);
        step_chk("n5_c2", 2, 1, 0, 0, 0, 0);
        step_chk("n5_c3", 3, 1, 0, 0, 0, 0);
        step_chk("n5_c4", 4, 0, 0, 0, 0, 0);
        step_chk("n5_c0", 0, 0, 1, 0, 0, 0);
        step_chk("n5_c1b", 1, 1, 0, 0, 0, 0);

        // Load N=1, D=1
        load_req = 1'b1; div_in = 7'd1; duty_in = 7'd1;
        step_chk("ld1_cap", 2, 1, 0, 1, 0, 0);
        load_req = 1'b0;
        step_chk("ld1_w3", 3, 1, 0, 1, 0, 0);
        step_chk("ld1_w4", 4, 0, 0, 1, 0, 0);
        step_chk("ld1_apply", 0, 0, 1, 0, 1, 0);
        step_chk("n1_a", 0, 1, 1, 0, 0, 0);
        step_chk("n1_b", 0, 1, 1, 0, 0, 0);

        // Load N=10, D=0
        load_req = 1'b1; div_in = 7'd10; duty_in = 7'd0;
        step_chk("ld10d0_cap", 0, 1, 1, 1, 0, 0);
        load_req = 1'b0;
        step_chk("ld10d0_apply", 0, 1, 1, 0, 1, 0);
        for (int i = 1; i <= 9; i++) step_chk("n10d0_run", i, 0, 0, 0, 0, 0);
        step_chk("n10d0_wrap", 0, 0, 1, 0, 0, 0);

        // Load N=10, D=127
        load_req = 1'b1; div_in = 7'd10; duty_in = 7'd127;
        step_chk("ld10d127_cap", 1, 0, 0, 1, 0, 0);
        load_req = 1'b0;
        for (int i = 2; i <= 9; i++) step_chk("ld10d127_wait", i, 0, 0, 1, 0, 0);
        step_chk("ld10d127_apply", 0, 0, 1, 0, 1, 0);
        for (int i = 1; i <= 9; i++) step_chk("n10d127_run", i, 1, 0, 0, 0, 0);
        step_chk("n10d127_wrap", 0, 1, 1, 0, 0, 0);

        // div_in = 0 is rejected with a single error pulse
        load_req = 1'b1; div_in = 7'd0; duty_in = 7'd5;
        step_chk("err_pulse", 1, 1, 0, 0, 0, 1);
        load_req = 1'b0;
        step_chk("err_clear", 2, 1, 0, 0, 0, 0);

        // Second request while busy is ignored
        load_req = 1'b1; div_in = 7'd3; duty_in = 7'd1;
        step_chk("ld3_cap", 3, 1, 0, 1, 0, 0);
        div_in = 7'd7; duty_in = 7'd7;
        step_chk("ld7_ignored", 4, 1, 0, 1, 0, 0);
        load_req = 1'b0;
        for (int i = 5; i <= 9; i++) step_chk("ld3_wait", i, 1, 0, 1, 0, 0);
        step_chk("ld3_apply", 0, 1, 1, 0, 1, 0);
        step_chk("n3_c1", 1, 1, 0, 0, 0, 0);
        step_chk("n3_c2", 2, 0, 0, 0, 0, 0);
        step_chk("n3_c0", 0, 0, 1, 0, 0, 0);
        step_chk("n3_c1b", 1, 1, 0, 0, 0, 0);

        // en drop with a pending load applies it on the next edge
        load_req = 1'b1; div_in = 7'd6; duty_in = 7'd4;
        step_chk("ld6_cap", 2, 0, 0, 1, 0, 0);
        load_req = 1'b0;
        en = 1'b0;
        step_chk("dis_apply", 0, 0, 0, 0, 1, 0);
        step_chk("dis_hold", 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        step_chk("n6_c1", 1, 1, 0, 0, 0, 0);
        step_chk("n6_c2", 2, 1, 0, 0, 0, 0);
        step_chk("n6_c3", 3, 1, 0, 0, 0, 0);
        step_chk("n6_c4", 4, 1, 0, 0, 0, 0);
        step_chk("n6_c5", 5, 0, 0, 0, 0, 0);
        step_chk("n6_c0", 0, 0, 1, 0, 0, 0);

        // Async reset mid-period with a load pending
        load_req = 1'b1; div_in = 7'd9; duty_in = 7'd9;
        step_chk("ld9_cap", 1, 1, 0, 1, 0, 0);
        load_req = 1'b0;
        step_chk("ld9_wait", 2, 1, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk("async_rst", 0, 0, 0, 0, 0, 0);
        step_chk("rst_held", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step_chk("post_e1", 1, 1, 0, 0, 0, 0);
        step_chk("post_e2", 2, 1, 0, 0, 0, 0);
        step_chk("post_e3", 3, 0, 0, 0, 0, 0);
        step_chk("post_e4", 0, 0, 1, 0, 0, 0);
        step_chk("post_e5", 1, 1, 0, 0, 0, 0);
        step_chk("post_e6", 2, 1, 0, 0, 0, 0);
        step_chk("post_e7", 3, 0, 0, 0, 0, 0);
        step_chk("post_e8", 0, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/programmable_clock_divider_7_bit.md
Name: programmable_clock_divider_7_bit

Overview:
Programmable clock divider for the clock_source_generation path. A 7-bit free-running period counter feeds two magnitude_comparator_7_bit instances:
- count vs. (div − 1) gives the period wrap.
- count vs. duty gives the high phase.

It produces a divided clock-enable waveform (clk_out) and a once-per-period tick. Divide and duty settings are loaded through a req/ack handshake and take effect only on a period boundary, so clk_out never carries a truncated period.

Parameters:
DEFAULT_DIV, 4, period in clk cycles after reset; legal range 1..127.
DEFAULT_DUTY, 2, high-phase length in clk cycles after reset; legal range 0..127.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  reset, asynchronous, active-high.
en  input  1  run enable; low holds the counter at 0.
load_req  input  1  request to load div_in/duty_in; sampled each edge.
div_in  input  7  requested period N (1..127); 0 is illegal.
duty_in  input  7  requested high-phase length D (0..127).
load_busy  output  1  high while a captured setting is waiting to be applied.
load_ack  output  1  one-cycle pulse on the edge the pending setting becomes active.
load_err  output  1  one-cycle pulse when a load_req carried div_in = 0.
cnt_out  output  7  current period count.
clk_out  output  1  divided waveform, registered.
tick  output  1  one-cycle pulse, registered; marks the last count of each period.

Behaviour:
Reset:
- rst high asynchronously forces cnt = 0, div_act = DEFAULT_DIV, duty_act = DEFAULT_DUTY, pending = 0.
- It also forces clk_out, tick, load_busy, load_ack and load_err to 0.
- Any pending load is discarded. State is held until rst is released.

Counting (en = 1), per edge:
- If cnt == div_act − 1 (comparator eq): cnt ← 0 (wrap). Otherwise cnt ← cnt + 1.
- Arithmetic is 7-bit unsigned; cnt never exceeds div_act − 1.

Outputs (one-cycle lag behind cnt):
- clk_out ← en & (cnt < duty_act), from the comparator lt output.
- tick ← en & (cnt == div_act − 1).

Resulting waveform:
- Period is N cycles, with min(D, N) high cycles per period.
- D = 0 gives clk_out constant 0.
- D ≥ N gives clk_out constant 1.
- N = 1 gives tick every cycle and cnt constant 0.

Disabled (en = 0):
- cnt ← 0; clk_out ← 0; tick ← 0.
- Re-enabling restarts the period from cnt = 0.

Load handshake (flag: pending = load_busy):
- load_req = 1, pending = 0, div_in ≠ 0: capture div_sh ← div_in and duty_sh ← duty_in; pending ← 1.
- load_req = 1, pending = 0, div_in = 0: nothing is captured; load_err pulses on the next cycle.
- load_req = 1, pending = 1: the request is ignored with no error. The requester must wait for load_busy = 0.

Applying a pending load:
- en = 1: apply on the wrap edge (cnt == div_act − 1). div_act ← div_sh, duty_act ← duty_sh, pending ← 0, load_ack pulses.
- tick and clk_out on that edge still use the old settings. The new settings govern from cnt = 0 onward.
- en = 0: apply on the next edge.

Simultaneous events:
- A load_req on the same edge that applies the pending load is ignored, because pending = 1 at that edge.
- en falling while a load is pending causes the load to apply on the next edge.

Test Plan:
1. Release rst, en = 1, defaults (N = 4, D = 2) -> cnt 0,1,2,3,0,1…; clk_out 0 then repeating 1,1,0,0 lagging cnt by one cycle; tick high the cycle after each cnt = 3.
2. At cnt = 1, load_req with div_in = 5, duty_in = 3 -> load_busy = 1 next cycle; applied at the cnt = 3 wrap edge with one load_ack pulse and load_busy → 0; subsequent periods are 5 cycles with clk_out 1,1,1,0,0.
3. Load N = 1, D = 1 -> clk_out steady 1, tick every cycle, cnt constant 0. Then load N = 10, D = 0 -> clk_out steady 0. Then load N = 10, D = 127 -> clk_out steady 1; tick every 10 cycles.
4. load_req with div_in = 0 -> single load_err pulse, load_busy stays 0, period unchanged. Second load_req issued while load_busy = 1 -> ignored; the first setting is the one applied.
5. Drop en with a load pending -> next edge: cnt = 0, load_ack pulse, load_busy = 0, clk_out = 0, tick = 0. Re-raise en -> new period starts from 0 with the new settings.
6. Assert rst mid-period (cnt = 2, pending = 1) -> all outputs 0 immediately without a clock edge. After release: defaults N = 4, D = 2, no load_ack ever issued for the dropped load.
